// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one single-port BRAM between the CPU and the loader, with sub-word stores done as read-modify-write.
// Round-robin arbitration by default; define MEM_ARB_FIXED_PRIO_EN to give the CPU fixed priority.
module mem_access_arbiter #(
  parameter int MEM_AW = 14,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  input  logic [DW/8-1:0]   cpu_be,
  output logic              cpu_ready,
  output logic [DW-1:0]     cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DW-1:0]     ld_wdata,
  input  logic [DW/8-1:0]   ld_be,
  output logic              ld_ready,
  output logic [DW-1:0]     ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;
  state_t state, state_nxt;
  logic grant, win, own, we_q, full_w, null_w, done;
  logic [MEM_AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, merged, cpu_rdata_q, ld_rdata_q;
  logic [DW/8-1:0] be_q;
  logic unused;
  assign unused = ^{cpu_addr[31:MEM_AW+2], cpu_addr[1:0], ld_addr[31:MEM_AW+2], ld_addr[1:0]};
  assign grant = state == IDLE && (cpu_req || ld_req);
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win = !cpu_req;
`else
  logic last_owner;
  // win/own/last_owner: 1 = loader, 0 = CPU
  assign win = cpu_req && ld_req ? !last_owner : !cpu_req;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_owner <= 1'b1;
    else if (grant) last_owner <= win;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (grant ? ACCESS : IDLE) :
                state == ACCESS && !(full_w || null_w) ? FINISH : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      own <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else if (grant) begin
      own <= win;
      we_q <= win ? ld_we : cpu_we;
      addr_q <= win ? ld_addr[MEM_AW+1:2] : cpu_addr[MEM_AW+1:2];
      wdata_q <= win ? ld_wdata : cpu_wdata;
      be_q <= win ? ld_be : cpu_be;
    end
  // Read data is captured at completion and held until that requester's next read
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cpu_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else if (state == FINISH && !we_q) begin
      if (own) ld_rdata_q <= mem_rdata;
      else cpu_rdata_q <= mem_rdata;
    end
  for (genvar i = 0; i < DW/8; i++)
    assign merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
  always_comb begin
    full_w = we_q && &be_q;
    null_w = we_q && be_q == '0;
    done = state == FINISH || (state == ACCESS && (full_w || null_w));
    mem_en = state == ACCESS ? !null_w : state == FINISH && we_q;
    mem_we = state == ACCESS ? full_w : state == FINISH && we_q;
    mem_addr = state == IDLE ? '0 : addr_q;
    mem_wdata = state == ACCESS && full_w ? wdata_q : state == FINISH && we_q ? merged : '0;
    cpu_ready = done && !own;
    ld_ready = done && own;
    cpu_rdata = state == FINISH && !we_q && !own ? mem_rdata : cpu_rdata_q;
    ld_rdata = state == FINISH && !we_q && own ? mem_rdata : ld_rdata_q;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed and random traffic from both requesters against a transaction-level reference.
module tb_mem_access_arbiter;
  localparam int AW = 14;
  logic clk = 0, reset = 0;
  logic cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_wdata = 0;
  logic [3:0] cpu_be = 0, ld_be = 0;
  logic cpu_ready, ld_ready, mem_en, mem_we, busy;
  logic [31:0] cpu_rdata, ld_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [AW-1:0] mem_addr;
  bit [31:0] bram [1<<AW];
  bit [31:0] ref_mem [1<<AW];
  int checks = 0, failures = 0;

  mem_access_arbiter #(.MEM_AW(AW), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_be(ld_be),
    .ld_ready(ld_ready), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else mem_rdata <= bram[mem_addr];
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one transaction at a time; winner chosen from the requests pending while idle
  int cyc = 0, cur = -1, gcyc = 0, last = 1, k, dur, w;
  bit o_we, fin;
  logic [31:0] o_a, o_d, old, nw;
  logic [3:0] o_be;
  logic [AW-1:0] wa;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      cur = -1;
      last = 1;
      check("rst_ctl", {27'd0, mem_en, mem_we, busy, cpu_ready, ld_ready}, 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_rdata", cpu_rdata | ld_rdata, 0);
    end else begin
      k = cyc - gcyc;
      dur = (o_we && (o_be == 4'hF || o_be == 4'h0)) ? 1 : 2;
      wa = o_a[AW+1:2];
      old = ref_mem[wa];
      for (int i = 0; i < 4; i++) nw[8*i +: 8] = o_be[i] ? o_d[8*i +: 8] : old[8*i +: 8];
      fin = cur >= 0 && k == dur;
      check("busy", busy, cur >= 0);
      check("cpu_ready", cpu_ready, fin && cur == 0);
      check("ld_ready", ld_ready, fin && cur == 1);
      if (!(cur >= 0 && !o_we && k == 2)) check("mem_en", mem_en, cur >= 0 && !(o_we && o_be == 0));
      check("mem_we", mem_we, cur >= 0 && o_we && o_be != 0 && (o_be == 4'hF || k == 2));
      if (mem_en && cur >= 0) check("mem_addr", 32'(mem_addr), 32'(wa));
      if (mem_we && cur >= 0) check("mem_wdata", mem_wdata, nw);
      if (fin) begin
        if (o_we) ref_mem[wa] = nw;
        else check(cur ? "ld_rdata" : "cpu_rdata", cur ? ld_rdata : cpu_rdata, old);
        cur = -2;
      end
      if (cur == -1 && (cpu_req || ld_req)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = cpu_req ? 0 : 1;
`else
        w = (cpu_req && ld_req) ? 1 - last : (cpu_req ? 0 : 1);
`endif
        o_we = w ? ld_we : cpu_we;
        o_a = w ? ld_addr : cpu_addr;
        o_d = w ? ld_wdata : cpu_wdata;
        o_be = w ? ld_be : cpu_be;
        cur = w;
        gcyc = cyc;
        last = w;
      end
      if (cur == -2) cur = -1;
    end
  end

  task automatic set_req(input bit who, input bit r, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (who) begin
      ld_req = r; ld_we = we; ld_addr = a; ld_wdata = d; ld_be = be;
    end else begin
      cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    end
  endtask

  task automatic drive(input bit who, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    set_req(who, 1, we, a, d, be);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (who ? ld_ready : cpu_ready) break;
    end
    check(who ? "ld_done" : "cpu_done", who ? ld_ready : cpu_ready, 1);
    rd = who ? ld_rdata : cpu_rdata;
    set_req(who, 0, 0, 0, 0, 0);
  endtask

  task automatic tie(output time tc, output time tl);
    logic [31:0] r0, r1;
    int l0, l1;
    fork
      begin drive(0, 0, 32'h10, 0, 0, r0, l0); tc = $time; end
      begin drive(1, 1, 32'h24, 32'h600DF00D, 4'hF, r1, l1); tl = $time; end
    join
  endtask

  task automatic rand_ops(input bit who, input int n);
    logic [31:0] rd, a;
    logic [3:0] be;
    int lat;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      be = ($urandom_range(0, 3) == 0) ? 4'hF : ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 8)) << 2) | 32'($urandom_range(0, 3));
      drive(who, 1'($urandom), a, $urandom, be, rd, lat);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, l2;
    time tc, tl;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    drive(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat); check("full_wr_lat", lat, 1);
    drive(0, 0, 32'h10, 0, 0, rd, lat); check("rd_lat", lat, 2); check("rd_data", rd, 32'hDEADBEEF);
    drive(0, 1, 32'h10, 32'h00AA0000, 4'b0100, rd, lat); check("rmw_lat", lat, 2);
    drive(0, 0, 32'h10, 0, 0, rd, lat); check("rmw_lane2", rd, 32'hDEAABEEF);
    drive(0, 1, 32'h10, 32'h00001234, 4'b0011, rd, lat);
    drive(0, 0, 32'h10, 0, 0, rd, lat); check("rmw_lane01", rd, 32'hDEAA1234);
    drive(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, lat); check("null_lat", lat, 1);
    drive(0, 0, 32'h10, 0, 0, rd, lat); check("null_keep", rd, 32'hDEAA1234);
    drive(0, 1, 32'hABCD_0016, 32'h5555AAAA, 4'hF, rd, lat);
    drive(1, 0, 32'h0000_0014, 0, 0, rd, lat); check("alias_ld_rd", rd, 32'h5555AAAA);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1 reset = 1;
    tie(tc, tl); check("tie1_cpu_first", tc < tl, 1);
    tie(tc, tl); check("tie2_cpu_first", tc < tl, 1);
    drive(0, 0, 32'h10, 0, 0, rd, lat);
    tie(tc, tl);
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("tie3_cpu_first", tc < tl, 1);
`else
    check("tie3_ld_first", tl < tc, 1);
`endif
    fork
      drive(1, 1, 32'h20, 32'h0000BB00, 4'b0010, rd, lat);
      begin @(posedge clk); drive(0, 0, 32'h10, 0, 0, rd, l2); end
    join
    check("cpu_wait_lat", l2, 4);
    drive(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    @(posedge clk); #1 set_req(0, 1, 1, 32'h10, 32'h00000011, 4'b0001);
    @(posedge clk); #1;
    @(posedge clk); #1 check("rmw_finish_we", mem_we, 1);
    reset = 0;
    set_req(0, 0, 0, 0, 0, 0);
    #1 check("rst_async_we", {30'd0, mem_we, busy}, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1;
    drive(0, 0, 32'h10, 0, 0, rd, lat); check("rst_no_merge", rd, 32'hDEADBEEF);
    fork
      rand_ops(0, 150);
      rand_ops(1, 150);
    join
    for (int i = 0; i <= 8; i++) check("mem_final", bram[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
